nes_multi_pad_reader: RTL and testbench

//  Parametrised NES/SNES serial pad reader for the Pong game logic. Drives one shared latch/clock pair to NUM_PADS pads.

---
 rtl/nes_multi_pad_reader_pkg.sv | 31 +++
 rtl/nes_input_sync.sv | 34 +++
 rtl/nes_multi_pad_reader.sv | 209 ++++++++++++++++++++
 tb/tb_nes_multi_pad_reader.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nes_multi_pad_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nes_pkg
//  Description : Shared types and constants for the NES/SNES pad reader:
//                transaction state encoding and NES button bit positions.
//  Revision    : 1.0 - initial release
// ============================================================================
package nes_pkg;

    // Serial transaction phases
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LATCH = 3'd1,
        FIRST = 3'd2,
        LOW   = 3'd3,
        HIGH  = 3'd4,
        DONE  = 3'd5
    } state_t;

    // Bit position of each button inside one pad's BITS-wide field
    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

endpackage : nes_pkg
`default_nettype wire

// File: rtl/nes_input_sync.sv
`default_nettype none
// ============================================================================
//  Module      : nes_input_sync
//  Description : Two-flop synchronizer for the asynchronous pad data lines.
//                Resets to all-ones, i.e. the released (pulled-up) level.
//  Revision    : 1.0 - initial release
// ============================================================================
module nes_input_sync #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Two-stage resynchronisation of every data line
    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule : nes_input_sync
`default_nettype wire

// File: rtl/nes_multi_pad_reader.sv
`default_nettype none
// ============================================================================
//  Module      : nes_multi_pad_reader
//  Description : Reads NUM_PADS NES/SNES pads in parallel over one shared
//                latch/clock pair. Publishes per-frame button state, press
//                edges and a one-cycle valid strobe after each poll.
//  Revision    : 1.0 - initial release
// ============================================================================
module nes_multi_pad_reader
    import nes_pkg::*;
#(
    parameter int NUM_PADS    = 2,
    parameter int BITS        = 8,
    parameter int HALF_PERIOD = 150,
    parameter int AUTO_POLL   = 0,
    parameter int POLL_PERIOD = 419583
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     poll_req,
    input  logic [NUM_PADS-1:0]      nes_data,
    output logic                     nes_latch,
    output logic                     nes_clk,
    output logic [NUM_PADS*BITS-1:0] buttons,
    output logic [NUM_PADS*BITS-1:0] pressed,
    output logic                     valid,
    output logic                     busy
);

    // LATCH is the longest phase (two half-periods), so it sizes the counter
    localparam int HP_W = $clog2(2 * HALF_PERIOD);
    localparam int BC_W = $clog2(BITS);
    localparam int TM_W = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;

    state_t                            r_state;
    state_t                            w_state_next;
    logic   [HP_W-1:0]                 r_hp_cnt;
    logic   [BC_W-1:0]                 r_bit_cnt;
    logic                              r_pending;
    logic                              r_latch;
    logic                              r_clk;
    logic   [NUM_PADS-1:0][BITS-1:0]   r_shift;
    logic   [NUM_PADS-1:0][BITS-1:0]   r_buttons;
    logic   [NUM_PADS-1:0][BITS-1:0]   r_pressed;
    logic                              r_valid;
    logic   [NUM_PADS-1:0][BITS-1:0]   w_new_buttons;
    logic   [NUM_PADS-1:0]             w_data_sync;
    logic                              w_wrap;
    logic                              w_trigger;
    logic                              w_start;
    logic                              w_sample;
    logic                              w_last_sample;
    logic                              w_hp_last;
    logic                              w_latch_last;

    nes_input_sync #(
        .WIDTH (NUM_PADS)
    ) u_sync (
        .clk     (clk),
        .reset   (reset),
        .i_async (nes_data),
        .o_sync  (w_data_sync)
    );

    // Free-running poll timer; exists only in auto-poll builds
    if (AUTO_POLL != 0) begin : g_auto_timer
        logic [TM_W-1:0] r_timer;

        // Count 0..POLL_PERIOD-1 regardless of transaction activity
        always_ff @(posedge clk) begin
            if (reset) begin
                r_timer <= '0;
            end else if (r_timer == TM_W'(POLL_PERIOD - 1)) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + 1'b1;
            end
        end

        assign w_wrap = (r_timer == TM_W'(POLL_PERIOD - 1));
    end else begin : g_no_timer
        assign w_wrap = 1'b0;
    end

    assign w_trigger    = (AUTO_POLL != 0) ? w_wrap : poll_req;
    assign w_hp_last    = (r_hp_cnt == HP_W'(HALF_PERIOD - 1));
    assign w_latch_last = (r_hp_cnt == HP_W'(2 * HALF_PERIOD - 1));

    // Next-state decode and sample strobes for the serial transaction
    always_comb begin
        w_state_next  = r_state;
        w_start       = 1'b0;
        w_sample      = 1'b0;
        w_last_sample = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_pending || w_trigger) begin
                    w_start      = 1'b1;
                    w_state_next = LATCH;
                end
            end
            LATCH: begin
                if (w_latch_last) begin
                    w_state_next = FIRST;
                end
            end
            FIRST: begin
                if (w_hp_last) begin
                    w_sample     = 1'b1;
                    w_state_next = LOW;
                end
            end
            LOW: begin
                if (w_hp_last) begin
                    w_state_next = HIGH;
                end
            end
            HIGH: begin
                if (w_hp_last) begin
                    w_sample = 1'b1;
                    if (r_bit_cnt == BC_W'(BITS - 1)) begin
                        w_last_sample = 1'b1;
                        w_state_next  = DONE;
                    end else begin
                        w_state_next  = LOW;
                    end
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Final frame: shift registers with the top bit taken straight from the line
    always_comb begin
        w_new_buttons = r_shift;
        for (int p = 0; p < NUM_PADS; p++) begin
            w_new_buttons[p][BITS-1] = ~w_data_sync[p];
        end
    end

    // State, counters, pending flag, pad outputs and published button state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_hp_cnt  <= '0;
            r_bit_cnt <= '0;
            r_pending <= 1'b0;
            r_latch   <= 1'b0;
            r_clk     <= 1'b1;
            r_shift   <= '0;
            r_buttons <= '0;
            r_pressed <= '0;
            r_valid   <= 1'b0;
        end else begin
            r_state <= w_state_next;

            // Half-period counter restarts on every phase change, parked in IDLE
            if (r_state == IDLE || w_state_next != r_state) begin
                r_hp_cnt <= '0;
            end else begin
                r_hp_cnt <= r_hp_cnt + 1'b1;
            end

            // Bit index of the next sample; stops at BITS-1
            if (w_start) begin
                r_bit_cnt <= '0;
            end else if (w_sample && !w_last_sample) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end

            // One held request; a trigger that starts the reader directly is not held
            r_pending <= (r_pending & ~w_start) | (w_trigger & (r_state != IDLE));

            // Outputs follow the upcoming state so they are glitch-free registers
            r_latch <= (w_state_next == LATCH);
            r_clk   <= (w_state_next != LOW);

            if (w_sample) begin
                for (int p = 0; p < NUM_PADS; p++) begin
                    r_shift[p][r_bit_cnt] <= ~w_data_sync[p];
                end
            end

            // Publish on entry to DONE so valid coincides with the new values
            if (w_last_sample) begin
                r_buttons <= w_new_buttons;
                r_pressed <= w_new_buttons & ~r_buttons;
                r_valid   <= 1'b1;
            end else begin
                r_pressed <= '0;
                r_valid   <= 1'b0;
            end
        end
    end

    assign nes_latch = r_latch;
    assign nes_clk   = r_clk;
    assign buttons   = r_buttons;
    assign pressed   = r_pressed;
    assign valid     = r_valid;
    assign busy      = (r_state != IDLE);

endmodule : nes_multi_pad_reader
`default_nettype wire

// File: tb/tb_nes_multi_pad_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nes_multi_pad_reader
//  Description : Directed self-checking bench: a manual-poll NES reader with
//                shift-register pad models, plus an auto-poll SNES instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nes_multi_pad_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        poll_req;
    logic [1:0]  nes_data;
    logic        nes_latch;
    logic        nes_clk;
    logic [15:0] buttons;
    logic [15:0] pressed;
    logic        valid;
    logic        busy;

    logic [1:0]  a_data;
    logic        a_latch;
    logic        a_clk;
    logic [31:0] a_buttons;
    logic [31:0] a_pressed;
    logic        a_valid;
    logic        a_busy;

    logic [7:0]  pad0_raw = 8'hFF;
    logic [7:0]  pad1_raw = 8'hFF;
    logic [7:0]  sr0      = 8'hFF;
    logic [7:0]  sr1      = 8'hFF;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    nes_multi_pad_reader #(
        .NUM_PADS    (2),
        .BITS        (8),
        .HALF_PERIOD (4),
        .AUTO_POLL   (0),
        .POLL_PERIOD (419583)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .poll_req  (poll_req),
        .nes_data  (nes_data),
        .nes_latch (nes_latch),
        .nes_clk   (nes_clk),
        .buttons   (buttons),
        .pressed   (pressed),
        .valid     (valid),
        .busy      (busy)
    );

    nes_multi_pad_reader #(
        .NUM_PADS    (2),
        .BITS        (16),
        .HALF_PERIOD (4),
        .AUTO_POLL   (1),
        .POLL_PERIOD (200)
    ) u_auto (
        .clk       (clk),
        .reset     (reset),
        .poll_req  (1'b0),
        .nes_data  (a_data),
        .nes_latch (a_latch),
        .nes_clk   (a_clk),
        .buttons   (a_buttons),
        .pressed   (a_pressed),
        .valid     (a_valid),
        .busy      (a_busy)
    );

    // Auto-poll pads: pad0 line held low (all pressed), pad1 absent
    assign a_data = 2'b10;

    // 4021-style pads: parallel load while latched, shift on nes_clk rise
    always @(posedge nes_latch) begin
        sr0 = pad0_raw;
        sr1 = pad1_raw;
    end

    always @(posedge nes_clk) begin
        if (!nes_latch) begin
            sr0 = {1'b1, sr0[7:1]};
            sr1 = {1'b1, sr1[7:1]};
        end
    end

    assign nes_data = {sr1[0], sr0[0]};

    // One poll_req in cycle 0, then observe cycles 1..100
    task automatic do_poll(output int vcyc, output int nfall, output int latch_err,
                           output int nvalid, output logic [15:0] b, output logic [15:0] pr);
        logic prev_clk;
        vcyc = -1; nfall = 0; latch_err = 0; nvalid = 0; b = '0; pr = '0;
        @(posedge clk); #1;
        poll_req = 1'b1;
        prev_clk = nes_clk;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk); #1;
            if (c == 1) poll_req = 1'b0;
            if (prev_clk && !nes_clk) nfall++;
            prev_clk = nes_clk;
            if (nes_latch !== (c >= 1 && c <= 8)) latch_err++;
            if (valid === 1'b1) begin
                nvalid++;
                if (vcyc < 0) begin
                    vcyc = c;
                    b    = buttons;
                    pr   = pressed;
                end
            end
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        poll_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (nes_latch !== 1'b0) begin failures++; $display("FAIL reset_latch: got %b expected 0", nes_latch); end
        checks++; if (nes_clk !== 1'b1) begin failures++; $display("FAIL reset_clk: got %b expected 1", nes_clk); end
        checks++; if (buttons !== 16'h0000) begin failures++; $display("FAIL reset_buttons: got %h expected 0000", buttons); end
        checks++; if (pressed !== 16'h0000) begin failures++; $display("FAIL reset_pressed: got %h expected 0000", pressed); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (a_latch !== 1'b0 || a_clk !== 1'b1 || a_busy !== 1'b0)
            begin failures++; $display("FAIL reset_auto_ctrl: got latch=%b clk=%b busy=%b expected 0 1 0", a_latch, a_clk, a_busy); end
        checks++; if (a_buttons !== 32'h0 || a_valid !== 1'b0)
            begin failures++; $display("FAIL reset_auto_out: got buttons=%h valid=%b expected 0 0", a_buttons, a_valid); end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_first_poll();
        int vcyc, nfall, lerr, nval;
        logic [15:0] b, pr;
        pad0_raw = 8'b1111_1010;
        pad1_raw = 8'hFF;
        do_poll(vcyc, nfall, lerr, nval, b, pr);
        checks++; if (lerr != 0) begin failures++; $display("FAIL poll1_latch_window: got %0d bad cycles expected 0", lerr); end
        checks++; if (nfall != 7) begin failures++; $display("FAIL poll1_clk_falls: got %0d expected 7", nfall); end
        checks++; if (vcyc != 69) begin failures++; $display("FAIL poll1_valid_cycle: got %0d expected 69", vcyc); end
        checks++; if (nval != 1) begin failures++; $display("FAIL poll1_valid_count: got %0d expected 1", nval); end
        checks++; if (b !== 16'h0005) begin failures++; $display("FAIL poll1_buttons: got %h expected 0005", b); end
        checks++; if (pr !== 16'h0005) begin failures++; $display("FAIL poll1_pressed: got %h expected 0005", pr); end
    endtask

    task automatic test_repeat_and_edge();
        int vcyc, nfall, lerr, nval;
        logic [15:0] b, pr;
        do_poll(vcyc, nfall, lerr, nval, b, pr);
        checks++; if (vcyc != 69) begin failures++; $display("FAIL poll2_valid_cycle: got %0d expected 69", vcyc); end
        checks++; if (b !== 16'h0005) begin failures++; $display("FAIL poll2_buttons: got %h expected 0005", b); end
        checks++; if (pr !== 16'h0000) begin failures++; $display("FAIL poll2_pressed: got %h expected 0000", pr); end
        pad1_raw = 8'b1111_0111;
        do_poll(vcyc, nfall, lerr, nval, b, pr);
        checks++; if (b !== 16'h0805) begin failures++; $display("FAIL poll3_buttons: got %h expected 0805", b); end
        checks++; if (pr !== 16'h0800) begin failures++; $display("FAIL poll3_pressed: got %h expected 0800", pr); end
        checks++; if (buttons !== 16'h0805) begin failures++; $display("FAIL poll3_hold: got %h expected 0805", buttons); end
    endtask

    task automatic test_back_to_back();
        int nval = 0;
        int v0 = -1;
        int v1 = -1;
        @(posedge clk); #1;
        poll_req = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            poll_req = (c == 10 || c == 20);
            if (valid === 1'b1) begin
                nval++;
                if (v0 < 0) v0 = c;
                else if (v1 < 0) v1 = c;
            end
        end
        poll_req = 1'b0;
        checks++; if (nval != 2) begin failures++; $display("FAIL b2b_valid_count: got %0d expected 2", nval); end
        checks++; if (v0 != 69) begin failures++; $display("FAIL b2b_first_valid: got %0d expected 69", v0); end
        checks++; if (v1 != 139) begin failures++; $display("FAIL b2b_second_valid: got %0d expected 139", v1); end
    endtask

    task automatic test_reset_mid();
        int nval = 0;
        @(posedge clk); #1;
        poll_req = 1'b1;
        for (int c = 1; c <= 120; c++) begin
            @(posedge clk); #1;
            if (c == 1) poll_req = 1'b0;
            if (c == 20) begin
                checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrst_busy_before: got %b expected 1", busy); end
                reset = 1'b1;
            end
            if (c == 21) begin
                checks++; if (nes_latch !== 1'b0) begin failures++; $display("FAIL midrst_latch: got %b expected 0", nes_latch); end
                checks++; if (nes_clk !== 1'b1) begin failures++; $display("FAIL midrst_clk: got %b expected 1", nes_clk); end
                checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b expected 0", busy); end
                checks++; if (buttons !== 16'h0000) begin failures++; $display("FAIL midrst_buttons: got %h expected 0000", buttons); end
                reset = 1'b0;
            end
            if (valid === 1'b1) nval++;
        end
        checks++; if (nval != 0) begin failures++; $display("FAIL midrst_no_valid: got %0d expected 0", nval); end
    endtask

    task automatic test_auto_poll();
        int rise[3];
        int nrise  = 0;
        int falls  = 0;
        int falls0 = -1;
        int vcyc   = -1;
        logic [31:0] vbtn = '0;
        logic pl, pc;
        pl = a_latch;
        pc = a_clk;
        for (int c = 1; c <= 700; c++) begin
            @(posedge clk); #1;
            if (!pl && a_latch) begin
                if (nrise == 1) falls0 = falls;
                if (nrise < 3) rise[nrise] = c;
                nrise++;
                falls = 0;
            end
            if (pc && !a_clk && nrise > 0) falls++;
            if (a_valid === 1'b1 && nrise == 1 && vcyc < 0) begin
                vcyc = c;
                vbtn = a_buttons;
            end
            pl = a_latch;
            pc = a_clk;
        end
        checks++; if (nrise < 3) begin failures++; $display("FAIL auto_latch_rises: got %0d expected >=3", nrise); end
        else begin
            checks++; if (rise[1] - rise[0] != 200) begin failures++; $display("FAIL auto_period_1: got %0d expected 200", rise[1] - rise[0]); end
            checks++; if (rise[2] - rise[1] != 200) begin failures++; $display("FAIL auto_period_2: got %0d expected 200", rise[2] - rise[1]); end
            checks++; if (falls0 != 15) begin failures++; $display("FAIL auto_clk_falls: got %0d expected 15", falls0); end
            checks++; if (vcyc - rise[0] != 132) begin failures++; $display("FAIL auto_valid_offset: got %0d expected 132", vcyc - rise[0]); end
            checks++; if (vbtn !== 32'h0000_FFFF) begin failures++; $display("FAIL auto_buttons: got %h expected 0000ffff", vbtn); end
        end
    endtask

    initial begin
        reset    = 1'b1;
        poll_req = 1'b0;
        test_reset();
        test_first_poll();
        test_repeat_and_edge();
        test_back_to_back();
        test_reset_mid();
        test_auto_poll();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_nes_multi_pad_reader
`default_nettype wire
